// File: rtl/healthcare_pkg.sv
// Shared definitions for the healthcare alarm blocks: default timing parameters,
// sequencer state encoding and buzzer drive modes.
package healthcare_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned ACK_TIMEOUT_DEF     = 16;
    localparam int unsigned BEEP_HALF_DEF       = 2;
    localparam int unsigned HOLDOFF_CYCLES_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUALIFY,
        ST_ALARM,
        ST_ESCALATED,
        ST_HOLDOFF
    } alarmState_t;

    typedef enum logic [1:0] {
        TONE_OFF,
        TONE_START,
        TONE_RUN,
        TONE_STEADY
    } toneMode_t;

    // Width of a counter that must hold values up to n without wrapping.
    function automatic int unsigned cntWidth(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// Buzzer drive: restartable square wave with a BEEP_HALF-cycle half period,
// plus a steady-on mode and an off mode.
module alarm_tone_gen
    import healthcare_pkg::*;
#(
    parameter int unsigned BEEP_HALF = BEEP_HALF_DEF
) (
    input  logic      clock,
    input  logic      reset,
    input  toneMode_t mode,
    output logic      buzzer
);

    localparam int unsigned W = cntWidth(BEEP_HALF);
    localparam logic [W-1:0] LAST = W'(BEEP_HALF - 1);

    logic [W-1:0] phaseCnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buzzer   <= 1'b0;
            phaseCnt <= '0;
        end else begin
            case (mode)
                TONE_START, TONE_STEADY: begin
                    buzzer   <= 1'b1;
                    phaseCnt <= '0;
                end
                TONE_RUN: begin
                    if (phaseCnt >= LAST) begin
                        buzzer   <= ~buzzer;
                        phaseCnt <= '0;
                    end else begin
                        phaseCnt <= phaseCnt + 1'b1;
                    end
                end
                default: begin
                    buzzer   <= 1'b0;
                    phaseCnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/warning_alarm_sequencer.sv
// Turns the controller's warning severity into a debounced, latched, acknowledgeable
// alarm with escalation to a remote nurse call and a post-acknowledge holdoff.
module warning_alarm_sequencer
    import healthcare_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned ACK_TIMEOUT     = ACK_TIMEOUT_DEF,
    parameter int unsigned BEEP_HALF       = BEEP_HALF_DEF,
    parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] warningLevel,
    input  logic       ack,
    output logic       alarmActive,
    output logic [2:0] alarmLevel,
    output logic       buzzer,
    output logic       escalate
);

    localparam int unsigned DW = cntWidth(DEBOUNCE_CYCLES);
    localparam int unsigned TW = cntWidth(ACK_TIMEOUT);
    localparam int unsigned HW = cntWidth(HOLDOFF_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [HW-1:0] HO_LAST = HW'(HOLDOFF_CYCLES - 1);

    alarmState_t  state;
    logic [2:0]   candidate;
    logic [2:0]   ackLevel;
    logic [DW-1:0] dbCount;
    logic [TW-1:0] toCount;
    logic [HW-1:0] hoCount;

    logic      match;
    logic      qualDone;
    logic      raise;
    logic      timeoutHit;
    toneMode_t toneMode;

    // Transition conditions are shared so the tone generator switches mode on the
    // same edge the state changes, keeping buzzer aligned with alarmActive/escalate.
    always_comb begin
        match      = (warningLevel == candidate);
        qualDone   = match && (dbCount >= DB_LAST);
        raise      = (warningLevel > alarmLevel);
        timeoutHit = (toCount >= TO_LAST);
        toneMode   = TONE_OFF;
        case (state)
            ST_QUALIFY:   if (warningLevel != '0 && qualDone) toneMode = TONE_START;
            ST_ALARM: begin
                if (ack)                     toneMode = TONE_OFF;
                else if (!raise && timeoutHit) toneMode = TONE_STEADY;
                else                         toneMode = TONE_RUN;
            end
            ST_ESCALATED: toneMode = ack ? TONE_OFF : TONE_STEADY;
            default:      toneMode = TONE_OFF;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            candidate   <= '0;
            ackLevel    <= '0;
            dbCount     <= '0;
            toCount     <= '0;
            hoCount     <= '0;
            alarmActive <= 1'b0;
            alarmLevel  <= '0;
            escalate    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (warningLevel != '0) begin
                        state     <= ST_QUALIFY;
                        candidate <= warningLevel;
                        dbCount   <= DW'(1);
                    end
                end
                ST_QUALIFY: begin
                    if (warningLevel == '0) begin
                        state   <= ST_IDLE;
                        dbCount <= '0;
                    end else if (!match) begin
                        candidate <= warningLevel;
                        dbCount   <= DW'(1);
                    end else if (qualDone) begin
                        state       <= ST_ALARM;
                        alarmActive <= 1'b1;
                        alarmLevel  <= candidate;
                        toCount     <= '0;
                        dbCount     <= '0;
                    end else if (dbCount != '1) begin
                        dbCount <= dbCount + 1'b1;
                    end
                end
                ST_ALARM, ST_ESCALATED: begin
                    if (ack) begin
                        state       <= ST_HOLDOFF;
                        ackLevel    <= alarmLevel;
                        alarmActive <= 1'b0;
                        alarmLevel  <= '0;
                        escalate    <= 1'b0;
                        toCount     <= '0;
                        hoCount     <= '0;
                    end else if (raise) begin
                        alarmLevel <= warningLevel;
                        toCount    <= '0;
                    end else if (state == ST_ALARM) begin
                        if (timeoutHit) begin
                            state    <= ST_ESCALATED;
                            escalate <= 1'b1;
                        end else if (toCount != '1) begin
                            toCount <= toCount + 1'b1;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (warningLevel > ackLevel) begin
                        state     <= ST_QUALIFY;
                        candidate <= warningLevel;
                        dbCount   <= DW'(1);
                        hoCount   <= '0;
                    end else if (hoCount >= HO_LAST) begin
                        state   <= ST_IDLE;
                        hoCount <= '0;
                    end else if (hoCount != '1) begin
                        hoCount <= hoCount + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    alarm_tone_gen #(
        .BEEP_HALF(BEEP_HALF)
    ) u_tone (
        .clock (clock),
        .reset (reset),
        .mode  (toneMode),
        .buzzer(buzzer)
    );

endmodule
